// File: rtl/offside.sv
// rtl/offside.sv - registered offside decision with rise pulse and saturating event counter
module offside #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  output logic             P,
  output logic             P_RISE,
  output logic [CNT_W-1:0] COUNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic p_next;
  logic rise_next;
  logic p_prev;

  // Offside only when ahead of ball and defender, in the opponents' half, not from a restart.
  always_comb begin
    p_next    = A & B & ~C & ~D;
    rise_next = p_next & ~P;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      P      <= 1'b0;
      P_RISE <= 1'b0;
      p_prev <= 1'b0;
      COUNT  <= '0;
    end else begin
      P      <= p_next;
      P_RISE <= rise_next;
      p_prev <= P;
      if (rise_next && (COUNT != CNT_MAX))
        COUNT <= COUNT + CNT_W'(1);
    end
  end

  // The registered pulse must always agree with the P history it was derived from.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (P_RISE == (P & ~p_prev));
  end

endmodule

// File: tb/tb_offside.sv
// tb/tb_offside.sv - directed self-checking bench for offside
module tb_offside;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic       p8, rise8, p2, rise2;
  logic [7:0] count8;
  logic [1:0] count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  offside #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .P(p8), .P_RISE(rise8), .COUNT(count8)
  );

  offside #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .P(p2), .P_RISE(rise2), .COUNT(count2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then look #1 after the rising edge that consumes it.
  task automatic step(input logic r, input logic [3:0] code);
    @(negedge clk);
    rst = r;
    {A, B, C, D} = code;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0000);
  endtask

  initial begin
    // Reset edge with 1100 applied: sample discarded
    step(1'b1, 4'b1100);
    check("reset_p", 16'(p8), 16'd0);
    check("reset_rise", 16'(rise8), 16'd0);
    check("reset_count", 16'(count8), 16'd0);
    check("reset_count2", 16'(count2), 16'd0);

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i));
      check($sformatf("sweep_p_%0d", i), 16'(p8), (i == 12) ? 16'd1 : 16'd0);
      check($sformatf("sweep_rise_%0d", i), 16'(rise8), (i == 12) ? 16'd1 : 16'd0);
    end
    check("sweep_count", 16'(count8), 16'd1);

    // Hold 1100 for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b1100);
      check($sformatf("hold_p_%0d", i), 16'(p8), 16'd1);
      check($sformatf("hold_rise_%0d", i), 16'(rise8), (i == 0) ? 16'd1 : 16'd0);
    end
    check("hold_count", 16'(count8), 16'd1);

    // Alternate 1100/1101 for 20 cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i % 2 == 0) ? 4'b1100 : 4'b1101);
      check($sformatf("alt_p_%0d", i), 16'(p8), (i % 2 == 0) ? 16'd1 : 16'd0);
      check($sformatf("alt_rise_%0d", i), 16'(rise8), (i % 2 == 0) ? 16'd1 : 16'd0);
      check($sformatf("alt_count_%0d", i), 16'(count8), 16'((i / 2) + 1));
    end
    check("alt_count_final", 16'(count8), 16'd10);

    // Narrow counter saturates at 3 while pulses continue
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1100);
      check($sformatf("sat_rise_%0d", i), 16'(rise2), 16'd1);
      check($sformatf("sat_count_%0d", i), 16'(count2), (i < 3) ? 16'(i + 1) : 16'd3);
      step(1'b0, 4'b0000);
      check($sformatf("sat_fall_%0d", i), 16'(p2), 16'd0);
    end
    check("sat_wide_count", 16'(count8), 16'd5);

    // Reset mid-operation with 1100 held and COUNT = 7
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'b1101);
      step(1'b0, 4'b1100);
    end
    check("pre_rst_count", 16'(count8), 16'd7);
    check("pre_rst_count2", 16'(count2), 16'd3);
    step(1'b1, 4'b1100);
    check("mid_rst_p", 16'(p8), 16'd0);
    check("mid_rst_rise", 16'(rise8), 16'd0);
    check("mid_rst_count", 16'(count8), 16'd0);
    check("mid_rst_count2", 16'(count2), 16'd0);
    step(1'b0, 4'b1100);
    check("post_rst_p", 16'(p8), 16'd1);
    check("post_rst_rise", 16'(rise8), 16'd1);
    check("post_rst_count", 16'(count8), 16'd1);
    step(1'b0, 4'b1100);
    check("post_rst_hold_rise", 16'(rise8), 16'd0);
    check("post_rst_hold_count", 16'(count8), 16'd1);

    // Own half and throw-in are never offside
    do_reset();
    step(1'b0, 4'b1110);
    check("own_half_p", 16'(p8), 16'd0);
    check("own_half_count", 16'(count8), 16'd0);
    step(1'b0, 4'b1101);
    check("throw_in_p", 16'(p8), 16'd0);
    check("throw_in_rise", 16'(rise8), 16'd0);
    check("throw_in_count", 16'(count8), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/offside.md
OFFSIDE -- requirements
Module: offside

Interface
REQ-001 Parameter CNT_W, default 8: width of the offside event counter; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  1  attacker is ahead of the ball.
REQ-005 B  input  1  attacker is ahead of the second-last defender.
REQ-006 C  input  1  attacker is in own half of the field.
REQ-007 D  input  1  ball received directly from a throw-in, goal kick or corner kick.
REQ-008 P  output  1  registered offside decision.
REQ-009 P_RISE  output  1  one-cycle pulse marking a new offside event.
REQ-010 COUNT  output  CNT_W  saturating count of offside events since reset.

Function
REQ-011 The combinational decision SHALL be p_next = A AND B AND (NOT C) AND (NOT D).
- Of the 16 input codes {A,B,C,D}, only 4'b1100 gives p_next = 1.
REQ-012 P SHALL be a register loaded with p_next on every rising clk edge when rst = 0.
- Latency is 1 cycle.
- There is no combinational path from the inputs to any output.
REQ-013 The block SHALL keep an internal register p_prev that holds the previous value of P.
REQ-014 P_RISE SHALL be registered and SHALL equal 1 for exactly one cycle when P goes from 0 to 1.
- P_RISE equals (p_next AND NOT P), sampled on the same edge that loads P.
- P_RISE is therefore asserted in the same cycle that P first reads 1.
REQ-015 COUNT SHALL increment by 1 on every edge that sets P_RISE to 1.
REQ-016 COUNT SHALL saturate at 2^CNT_W - 1.
- It does not wrap.
- P_RISE still pulses normally while COUNT is saturated.
REQ-017 When P stays 1 for many cycles, COUNT SHALL increment only once.
REQ-018 When P toggles 1-0-1 on consecutive cycles, each return to 1 SHALL count as a new event.
REQ-019 The inputs SHALL be treated as synchronous to clk.
- The block contains no synchronizers.
- X or Z on any input gives an undefined P and is outside specification.

Reset
REQ-020 While rst = 1 at a rising edge, the block SHALL load P = 0, P_RISE = 0, COUNT = 0 and p_prev = 0.
REQ-021 rst SHALL take priority over the decision logic in the same cycle.
- The input sampled on a reset edge is discarded.
- That sample does not generate an event.
REQ-022 On the first edge after rst falls, P SHALL reflect the inputs sampled at that edge.
- If those inputs are 1100, P_RISE = 1 and COUNT = 1.
REQ-023 Asserting rst mid-operation SHALL clear COUNT, even when COUNT is saturated.
- A held 1100 input after reset is released then counts as a new event.

Verification
REQ-024 Exhaustive sweep: step {A,B,C,D} through 0000..1111, one code per cycle, after reset.
- P is 1 only in the cycle after 1100 is applied.
- COUNT ends at 1.
REQ-025 Hold 1100 for 10 cycles.
- P = 1 for all 10 cycles.
- P_RISE is high for exactly the first of those cycles.
- COUNT = 1.
REQ-026 Alternate 1100/1101 for 20 cycles, starting with 1100.
- P toggles every cycle.
- P_RISE pulses 10 times.
- COUNT = 10.
REQ-027 With CNT_W = 2, generate 5 events.
- COUNT reads 1, 2, 3, 3, 3.
- P_RISE pulses 5 times.
REQ-028 Hold 1100 and assert rst for 1 cycle with COUNT = 7.
- At the reset edge: P = 0, COUNT = 0, P_RISE = 0.
- At the next edge: P = 1, P_RISE = 1, COUNT = 1.
REQ-029 Apply 1110 (own half) and 1101 (throw-in) after reset.
- P stays 0.
- COUNT stays 0.
